// File: rtl/round_controller_pkg.sv
// Shared types for the round controller: FSM states, winner codes and score width helper.
package game_pkg;

    typedef enum logic [1:0] {
        PLAY = 2'b00,
        HOLD = 2'b01,
        DONE = 2'b10
    } rc_state_t;

    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_P1   = 2'b01;
    localparam logic [1:0] WIN_P2   = 2'b10;

    function automatic int score_w(input int max_score);
        return $clog2(max_score + 1);
    endfunction

endpackage

// File: rtl/round_controller_if.sv
// Win-strobe / score bus between the win detectors, the round controller and the playfield.
interface round_controller_if #(
    parameter int SCORE_W = 3
) ();
    logic               p1_win;
    logic               p2_win;
    logic               round_rst;
    logic [SCORE_W-1:0] p1_score;
    logic [SCORE_W-1:0] p2_score;
    logic               match_over;
    logic [1:0]         winner;

    modport master (
        output p1_win, p2_win,
        input  round_rst, p1_score, p2_score, match_over, winner
    );

    modport slave (
        input  p1_win, p2_win,
        output round_rst, p1_score, p2_score, match_over, winner
    );
endinterface

// File: rtl/round_controller_score_counter.sv
// Per-player point counter; saturates at MAX so a stray increment can never wrap.
module score_counter #(
    parameter int MAX     = 7,
    parameter int SCORE_W = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               inc,
    output logic [SCORE_W-1:0] count,
    output logic               at_max
);
    logic [SCORE_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (reset)
            r_count <= '0;
        else if (inc && !at_max)
            r_count <= r_count + 1'b1;
    end

    assign count  = r_count;
    assign at_max = (r_count == SCORE_W'(MAX));
endmodule

// File: rtl/round_controller.sv
// Match scorekeeper: counts win strobes, times the round-reset strobe and freezes at MAX_SCORE.
module round_controller
    import game_pkg::*;
#(
    parameter int MAX_SCORE   = 7,
    parameter int HOLD_CYCLES = 4
) (
    input  logic              clk,
    input  logic              reset,
    round_controller_if.slave bus
);
    localparam int SCORE_W = score_w(MAX_SCORE);
    localparam int HOLD_W  = $clog2(HOLD_CYCLES + 1);

    rc_state_t          r_state, w_state_nxt;
    logic [HOLD_W-1:0]  r_hold,  w_hold_nxt;
    logic               w_inc1, w_inc2, w_last;
    logic [SCORE_W-1:0] w_p1_count, w_p2_count;
    logic               w_p1_max, w_p2_max;

    score_counter #(.MAX(MAX_SCORE), .SCORE_W(SCORE_W)) u_p1 (
        .clk(clk), .reset(reset), .inc(w_inc1), .count(w_p1_count), .at_max(w_p1_max)
    );

    score_counter #(.MAX(MAX_SCORE), .SCORE_W(SCORE_W)) u_p2 (
        .clk(clk), .reset(reset), .inc(w_inc2), .count(w_p2_count), .at_max(w_p2_max)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= PLAY;
            r_hold  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_hold  <= w_hold_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_hold_nxt  = r_hold;
        w_inc1      = 1'b0;
        w_inc2      = 1'b0;
        w_last      = 1'b0;
        case (r_state)
            PLAY: begin
                // Simultaneous strobes are a tie and score nothing.
                if (bus.p1_win ^ bus.p2_win) begin
                    w_inc1 = bus.p1_win;
                    w_inc2 = bus.p2_win;
                    w_last = bus.p1_win ? (w_p1_count == SCORE_W'(MAX_SCORE - 1))
                                        : (w_p2_count == SCORE_W'(MAX_SCORE - 1));
                    if (w_last) begin
                        w_state_nxt = DONE;
                    end else begin
                        w_state_nxt = HOLD;
                        w_hold_nxt  = HOLD_W'(HOLD_CYCLES - 1);
                    end
                end
            end
            HOLD: begin
                if (r_hold == '0)
                    w_state_nxt = PLAY;
                else
                    w_hold_nxt = r_hold - 1'b1;
            end
            DONE:    w_state_nxt = DONE;
            default: w_state_nxt = PLAY;
        endcase
    end

    // Counters only reach MAX on the final point, so at_max doubles as the winner flag.
    assign bus.round_rst  = (r_state != PLAY);
    assign bus.match_over = (r_state == DONE);
    assign bus.winner     = w_p1_max ? WIN_P1 : (w_p2_max ? WIN_P2 : WIN_NONE);
    assign bus.p1_score   = w_p1_count;
    assign bus.p2_score   = w_p2_count;
endmodule

// File: tb/tb_round_controller.sv
// Directed bench for round_controller (MAX_SCORE=7, HOLD_CYCLES=4).
module tb_round_controller;
    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    round_controller_if #(.SCORE_W(3)) bus ();

    round_controller #(.MAX_SCORE(7), .HOLD_CYCLES(4)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    typedef struct {
        logic       p1;
        logic       p2;
        logic [2:0] s1;
        logic [2:0] s2;
        logic       rr;
        logic       mo;
        logic [1:0] win;
    } vec_t;

    vec_t vecs[23];

    function automatic vec_t mk(input logic p1, input logic p2, input int s1, input int s2,
                                input logic rr, input logic mo, input logic [1:0] win);
        vec_t v;
        v.p1 = p1; v.p2 = p2; v.s1 = 3'(s1); v.s2 = 3'(s2);
        v.rr = rr; v.mo = mo; v.win = win;
        return v;
    endfunction

    task automatic check(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic check_all(input string name, input int s1, input int s2, input int rr,
                             input int mo, input int win);
        check({name, ".p1_score"},   int'(bus.p1_score),   s1);
        check({name, ".p2_score"},   int'(bus.p2_score),   s2);
        check({name, ".round_rst"},  int'(bus.round_rst),  rr);
        check({name, ".match_over"}, int'(bus.match_over), mo);
        check({name, ".winner"},     int'(bus.winner),     win);
    endtask

    // Drive inputs for one cycle; outputs are sampled 1 time unit after the edge.
    task automatic step(input logic p1, input logic p2);
        bus.p1_win = p1;
        bus.p2_win = p2;
        @(posedge clk);
        #1;
        bus.p1_win = 1'b0;
        bus.p2_win = 1'b0;
    endtask

    task automatic do_reset(input int cycles);
        reset = 1'b1;
        repeat (cycles) step(1'b0, 1'b0);
        reset = 1'b0;
    endtask

    // One point followed by enough idle cycles for HOLD to expire.
    task automatic point(input logic p1, input logic p2);
        step(p1, p2);
        repeat (4) step(1'b0, 1'b0);
    endtask

    initial begin
        bus.p1_win = 1'b0;
        bus.p2_win = 1'b0;

        // Rows 1-5: p1 point with a p2 strobe masked during HOLD; rows 6-10: p2 point;
        // rows 11-12: tie; rows 13-22: held strobe counts once, then again right after HOLD.
        vecs[0]  = mk(0, 0, 0, 0, 0, 0, 2'b00);
        vecs[1]  = mk(1, 0, 1, 0, 1, 0, 2'b00);
        vecs[2]  = mk(0, 1, 1, 0, 1, 0, 2'b00);
        vecs[3]  = mk(0, 0, 1, 0, 1, 0, 2'b00);
        vecs[4]  = mk(0, 0, 1, 0, 1, 0, 2'b00);
        vecs[5]  = mk(0, 0, 1, 0, 0, 0, 2'b00);
        vecs[6]  = mk(0, 1, 1, 1, 1, 0, 2'b00);
        vecs[7]  = mk(0, 0, 1, 1, 1, 0, 2'b00);
        vecs[8]  = mk(0, 0, 1, 1, 1, 0, 2'b00);
        vecs[9]  = mk(0, 0, 1, 1, 1, 0, 2'b00);
        vecs[10] = mk(0, 0, 1, 1, 0, 0, 2'b00);
        vecs[11] = mk(1, 1, 1, 1, 0, 0, 2'b00);
        vecs[12] = mk(0, 0, 1, 1, 0, 0, 2'b00);
        vecs[13] = mk(1, 0, 2, 1, 1, 0, 2'b00);
        vecs[14] = mk(1, 0, 2, 1, 1, 0, 2'b00);
        vecs[15] = mk(1, 0, 2, 1, 1, 0, 2'b00);
        vecs[16] = mk(1, 0, 2, 1, 1, 0, 2'b00);
        vecs[17] = mk(1, 0, 2, 1, 0, 0, 2'b00);
        vecs[18] = mk(1, 0, 3, 1, 1, 0, 2'b00);
        vecs[19] = mk(0, 0, 3, 1, 1, 0, 2'b00);
        vecs[20] = mk(0, 0, 3, 1, 1, 0, 2'b00);
        vecs[21] = mk(0, 0, 3, 1, 1, 0, 2'b00);
        vecs[22] = mk(0, 0, 3, 1, 0, 0, 2'b00);

        do_reset(2);
        repeat (5) step(1'b0, 1'b0);
        check_all("reset_idle", 0, 0, 0, 0, 0);

        for (int i = 0; i < 23; i++) begin
            step(vecs[i].p1, vecs[i].p2);
            check_all($sformatf("vec%0d", i), int'(vecs[i].s1), int'(vecs[i].s2),
                      int'(vecs[i].rr), int'(vecs[i].mo), int'(vecs[i].win));
        end

        // Player 1 takes the match from 0.
        do_reset(1);
        for (int k = 1; k <= 6; k++) begin
            point(1'b1, 1'b0);
            check_all($sformatf("p1_pt%0d", k), k, 0, 0, 0, 0);
        end
        step(1'b1, 1'b0);
        check_all("p1_match", 7, 0, 1, 1, 1);
        point(1'b1, 1'b0);
        point(1'b0, 1'b1);
        step(1'b1, 1'b1);
        check_all("done_frozen", 7, 0, 1, 1, 1);

        // Reset from DONE.
        do_reset(1);
        check_all("rst_done", 0, 0, 0, 0, 0);

        // Reset from HOLD, then confirm play resumes immediately.
        step(1'b0, 1'b1);
        check_all("enter_hold", 0, 1, 1, 0, 0);
        do_reset(1);
        check_all("rst_hold", 0, 0, 0, 0, 0);
        step(1'b1, 1'b0);
        check_all("post_rst_point", 1, 0, 1, 0, 0);

        // Player 2 takes the match.
        do_reset(1);
        repeat (6) point(1'b0, 1'b1);
        check_all("p2_six", 0, 6, 0, 0, 0);
        step(1'b0, 1'b1);
        check_all("p2_match", 0, 7, 1, 1, 2);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
